// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory.
package imem_pkg;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_RESP
  } imem_state_e;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;
  localparam logic [1:0] FAULT_PARITY   = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imem_array.sv
// 1R1W synchronous RAM; read data register is only updated on a read strobe,
// so it holds a response stable while writes continue underneath.
module imem_array #(
  parameter int DEPTH     = 256,
  parameter int WIDTH     = 32,
  parameter int IDX_W     = $clog2(DEPTH),
  parameter     INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-edge read and write to one index returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory with fetch handshake, boot-load port and
// post-reset clear. Define IMEM_PARITY_EN for per-word even parity and load_par_flip.
module instr_mem_sync
  import imem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 256,
  parameter     INIT_FILE      = "",
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  input  logic              fetch_ack,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_fault,
  output logic [1:0]        fault_cause,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
`ifdef IMEM_PARITY_EN
  input  logic              load_par_flip,
`endif
  output logic              load_ready,
  output logic              init_done
);

  localparam int IDX_W = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  imem_state_e      state, state_nx;
  logic [IDX_W-1:0] clr_cnt;
  logic [1:0]       cause_q;
  logic             accept, load_take, clearing;
  logic             misalign, out_range, load_in_range;
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [MEM_W-1:0] mem_wdata, rdata;
  logic             par_err;

  assign clearing      = (state == S_CLEAR);
  assign misalign      = |fetch_addr[1:0];
  assign out_range     = (fetch_addr >> 2) >= ADDR_W'(DEPTH);
  assign load_in_range = (load_addr >> 2) < ADDR_W'(DEPTH);

  // Gating on init_done keeps both ports closed during and straight after reset.
  always_comb begin
    state_nx    = state;
    fetch_ready = 1'b0;
    load_ready  = 1'b0;
    case (state)
      S_CLEAR: begin
        if (clr_cnt == IDX_W'(DEPTH - 1)) state_nx = S_IDLE;
      end
      S_IDLE: begin
        fetch_ready = init_done;
        load_ready  = init_done;
        if (fetch_req && fetch_ready) state_nx = S_RESP;
      end
      S_RESP: begin
        fetch_ready = init_done && fetch_ack;
        load_ready  = init_done;
        if (fetch_ack && !fetch_req) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign accept    = fetch_req && fetch_ready;
  assign load_take = load_we && load_ready && load_in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clr_cnt   <= '0;
      init_done <= 1'b0;
      cause_q   <= FAULT_NONE;
    end else begin
      state <= state_nx;
      if (clearing) clr_cnt <= clr_cnt + 1'b1;
      if (state_nx != S_CLEAR) init_done <= 1'b1;
      if (accept) begin
        if (misalign)       cause_q <= FAULT_MISALIGN;
        else if (out_range) cause_q <= FAULT_RANGE;
        else                cause_q <= FAULT_NONE;
      end
    end
  end

  always_comb begin
    mem_we    = clearing || load_take;
    mem_waddr = clearing ? clr_cnt : load_addr[IDX_W+1:2];
`ifdef IMEM_PARITY_EN
    mem_wdata = clearing ? '0 : {(^load_data) ^ load_par_flip, load_data};
`else
    mem_wdata = clearing ? '0 : load_data;
`endif
  end

  imem_array #(
    .DEPTH     (DEPTH),
    .WIDTH     (MEM_W),
    .IDX_W     (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (accept),
    .raddr (fetch_addr[IDX_W+1:2]),
    .rdata (rdata)
  );

  // Parity is judged on the registered word; address faults take precedence.
`ifdef IMEM_PARITY_EN
  assign par_err = ^rdata;
`else
  assign par_err = 1'b0;
`endif

  always_comb begin
    fault_cause = cause_q;
    if (cause_q == FAULT_NONE && par_err) fault_cause = FAULT_PARITY;
    fetch_fault = (fault_cause != FAULT_NONE);
    fetch_instr = fetch_fault ? DATA_W'(NOP_INSTR) : rdata[DATA_W-1:0];
  end

  assign fetch_valid = (state == S_RESP);

endmodule

// File: tb/tb_instr_mem_sync.sv
// Scoreboard bench for instr_mem_sync (DEPTH=16, clear on reset).
module tb_instr_mem_sync;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready, fetch_valid, fetch_fault;
  logic        fetch_ack = 1'b0;
  logic [31:0] fetch_instr;
  logic [1:0]  fault_cause;
  logic        load_we = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic        load_par_flip = 1'b0;
  logic        load_ready, init_done;

  instr_mem_sync #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_ack   (fetch_ack),
    .fetch_instr (fetch_instr),
    .fetch_fault (fetch_fault),
    .fault_cause (fault_cause),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
`ifdef IMEM_PARITY_EN
    .load_par_flip (load_par_flip),
`endif
    .load_ready  (load_ready),
    .init_done   (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  cause;
  } resp_t;

  resp_t       sbq[$];
  logic [31:0] model [DEPTH];
  logic        par_bad [DEPTH];
  int unsigned total = 0;
  int unsigned bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      model[i]   = '0;
      par_bad[i] = 1'b0;
    end
  endtask

  task automatic push_exp(input logic [31:0] addr);
    resp_t r;
    if (addr[1:0] != 2'b00) begin
      r.instr = 32'h0000_0013; r.cause = 2'b01;
    end else if ((addr >> 2) >= DEPTH) begin
      r.instr = 32'h0000_0013; r.cause = 2'b10;
    end else if (par_bad[addr[5:2]]) begin
      r.instr = 32'h0000_0013; r.cause = 2'b11;
    end else begin
      r.instr = model[addr[5:2]]; r.cause = 2'b00;
    end
    sbq.push_back(r);
  endtask

  task automatic check_resp(input string tag);
    resp_t r;
    chk({tag, "_valid"}, {31'b0, fetch_valid}, 32'd1);
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      r = sbq.pop_front();
      chk({tag, "_instr"}, fetch_instr, r.instr);
      chk({tag, "_cause"}, {30'b0, fault_cause}, {30'b0, r.cause});
      chk({tag, "_fault"}, {31'b0, fetch_fault}, {31'b0, (r.cause != 2'b00)});
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!fetch_valid && n < 10) begin
      cycle();
      n++;
    end
    if (!fetch_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] data, input logic flip);
    load_we = 1'b1; load_addr = addr; load_data = data; load_par_flip = flip;
    chk("load_ready", {31'b0, load_ready}, 32'd1);
    if ((addr >> 2) < DEPTH) begin
      model[addr[5:2]]   = data;
      par_bad[addr[5:2]] = flip;
    end
    cycle();
    load_we = 1'b0; load_par_flip = 1'b0;
  endtask

  task automatic fetch_one(input string tag, input logic [31:0] addr);
    fetch_req = 1'b1; fetch_addr = addr;
    chk({tag, "_ready"}, {31'b0, fetch_ready}, 32'd1);
    push_exp(addr);
    cycle();
    fetch_req = 1'b0;
    wait_valid(tag);
    check_resp(tag);
    fetch_ack = 1'b1;
    cycle();
    fetch_ack = 1'b0;
    chk({tag, "_drop"}, {31'b0, fetch_valid}, 32'd0);
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 40) begin
      cycle();
      n++;
      if (n < DEPTH) chk({tag, "_busy"}, {31'b0, fetch_ready | load_ready}, 32'd0);
    end
    chk({tag, "_clr_cycles"}, n, DEPTH);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    // Reset state
    cycle(); cycle();
    chk("rst_ready",  {31'b0, fetch_ready}, 32'd0);
    chk("rst_valid",  {31'b0, fetch_valid}, 32'd0);
    chk("rst_instr",  fetch_instr, 32'd0);
    chk("rst_fault",  {31'b0, fetch_fault}, 32'd0);
    chk("rst_cause",  {30'b0, fault_cause}, 32'd0);
    chk("rst_lready", {31'b0, load_ready}, 32'd0);
    chk("rst_init",   {31'b0, init_done}, 32'd0);
    rst = 1'b0;
    wait_init("t1");
    fetch_one("t1_idx5", 32'h14);

    // Load then fetch; response held with ack low, untouched by a concurrent load
    do_load(32'h8, 32'hDEADBEEF, 1'b0);
    fetch_req = 1'b1; fetch_addr = 32'h8;
    push_exp(32'h8);
    cycle();
    fetch_req = 1'b0;
    check_resp("t2");
    for (int i = 0; i < 3; i++) begin
      if (i == 1) do_load(32'h8, 32'h12345678, 1'b0);
      else cycle();
      chk("t2_hold_valid", {31'b0, fetch_valid}, 32'd1);
      chk("t2_hold_instr", fetch_instr, 32'hDEADBEEF);
      chk("t2_hold_rdy",   {31'b0, fetch_ready}, 32'd0);
    end
    fetch_ack = 1'b1; cycle(); fetch_ack = 1'b0;
    fetch_one("t2_refetch", 32'h8);

    // Faults and range boundary
    do_load(32'h3C, 32'hCAFEF00D, 1'b0);
    fetch_one("t3_mis", 32'h6);
    fetch_one("t3_range", 32'h40);
    fetch_one("t3_last", 32'h3C);
    do_load(32'h0, 32'h0BADC0DE, 1'b0);
    do_load(32'h40, 32'hAAAAAAAA, 1'b0);
    fetch_one("t3_drop", 32'h0);

    // Back-to-back with ack held high
    do_load(32'h4, 32'h22222222, 1'b0);
    fetch_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1'b1; fetch_addr = 32'(i * 4);
      chk("t4_ready", {31'b0, fetch_ready}, 32'd1);
      push_exp(32'(i * 4));
      cycle();
      check_resp("t4_b2b");
    end
    fetch_req = 1'b0;
    cycle();
    fetch_ack = 1'b0;
    chk("t4_idle", {31'b0, fetch_valid}, 32'd0);

    // Same-cycle load and fetch of one index returns the old word
    load_we = 1'b1; load_addr = 32'h4; load_data = 32'h11111111;
    fetch_req = 1'b1; fetch_addr = 32'h4;
    push_exp(32'h4);
    model[1] = 32'h11111111;
    cycle();
    load_we = 1'b0; fetch_req = 1'b0;
    check_resp("t5_old");
    fetch_ack = 1'b1; cycle(); fetch_ack = 1'b0;
    fetch_one("t5_new", 32'h4);

`ifdef IMEM_PARITY_EN
    do_load(32'hC, 32'h00000007, 1'b1);
    fetch_one("t6_par", 32'hC);
    do_load(32'hC, 32'h00000007, 1'b0);
    fetch_one("t6_par_ok", 32'hC);
`endif

    // Reset while a response is held
    fetch_req = 1'b1; fetch_addr = 32'h8;
    cycle();
    fetch_req = 1'b0;
    chk("t6_pre_valid", {31'b0, fetch_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {31'b0, fetch_valid}, 32'd0);
    chk("t6_rst_init",  {31'b0, init_done}, 32'd0);
    sbq.delete();
    model_clear();
    cycle();
    rst = 1'b0;
    wait_init("t6");
    fetch_one("t6_cleared", 32'h8);

    chk("sb_drained", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
